// File: rtl/tc4_calc_seq.sv
// 4-bit two's complement add/sub calculator sequenced by an Enter pushbutton; TC4_CALC_DEBOUNCE_EN adds an Enter debouncer.
// N/Ovf registered (1-cycle from Sw); Press acts 3 edges after Enter is first sampled; no backpressure, Press is a single pulse.
module tc4_calc_seq #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Sw,
  input  logic       Enter,
  input  logic       Op,
  output logic [3:0] N,
  output logic       Ovf,
  output logic [1:0] Mode
);

  typedef enum logic [1:0] {
    LOAD_A  = 2'b00,
    LOAD_B  = 2'b01,
    RESULT  = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] a_reg, a_nxt;
  logic [3:0] b_reg, b_nxt;
  logic       op_reg, op_nxt;
  logic [3:0] n_reg, n_nxt;
  logic       ovf_reg, ovf_nxt;

  logic       sync1, sync2;
  logic [1:0] fill;
  logic       armed;
  logic       cond, cond_d;
  logic       press;

  // armed only after a genuine low is seen post-reset, so an Enter held across reset release never fires
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      fill   <= 2'b00;
      armed  <= 1'b0;
      cond_d <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync1  <= Enter;
      sync2  <= sync1;
      fill   <= {fill[0], 1'b1};
      if (fill[1] && !sync2)
        armed <= 1'b1;
      cond_d <= cond;
      press  <= cond & ~cond_d & armed;
    end
  end

`ifdef TC4_CALC_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] db_cnt;
  logic          db_lvl;

  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt <= '0;
      db_lvl <= 1'b0;
    end else if (sync2 == db_lvl) begin
      db_cnt <= '0;
    end else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt <= '0;
      db_lvl <= sync2;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign cond = db_lvl;
`else
  assign cond = sync2;
`endif

  // returns {overflow, 4-bit wrapped result}
  function automatic logic [4:0] calc(input logic [3:0] x, input logic [3:0] y, input logic sub);
    logic [3:0] r;
    logic       v;
    r = sub ? (x - y) : (x + y);
    if (sub)
      v = (x[3] != y[3]) && (r[3] != x[3]);
    else
      v = (x[3] == y[3]) && (r[3] != x[3]);
    return {v, r};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= LOAD_A;
      a_reg   <= 4'b0000;
      b_reg   <= 4'b0000;
      op_reg  <= 1'b0;
      n_reg   <= 4'b0000;
      ovf_reg <= 1'b0;
    end else begin
      state   <= state_nxt;
      a_reg   <= a_nxt;
      b_reg   <= b_nxt;
      op_reg  <= op_nxt;
      n_reg   <= n_nxt;
      ovf_reg <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = a_reg;
    b_nxt     = b_reg;
    op_nxt    = op_reg;
    n_nxt     = Sw;
    ovf_nxt   = 1'b0;
    case (state)
      LOAD_A: begin
        if (press) begin
          a_nxt     = Sw;
          state_nxt = LOAD_B;
        end
      end
      LOAD_B: begin
        if (press) begin
          b_nxt              = Sw;
          op_nxt             = Op;
          {ovf_nxt, n_nxt}   = calc(a_reg, Sw, Op);
          state_nxt          = RESULT;
        end
      end
      RESULT: begin
        // recomputed from captured operands, so Sw/Op changes cannot disturb the display
        {ovf_nxt, n_nxt} = calc(a_reg, b_reg, op_reg);
        if (press) begin
          state_nxt = LOAD_A;
          n_nxt     = Sw;
          ovf_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = LOAD_A;
        n_nxt     = 4'b0000;
        ovf_nxt   = 1'b0;
      end
    endcase
  end

  assign N    = n_reg;
  assign Ovf  = ovf_reg;
  assign Mode = state;

endmodule

// File: tb/tb_tc4_calc_seq.sv
// Directed self-checking bench for tc4_calc_seq.
module tb_tc4_calc_seq;

  logic       clk;
  logic       reset;
  logic [3:0] Sw;
  logic       Enter;
  logic       Op;
  logic [3:0] N;
  logic       Ovf;
  logic [1:0] Mode;

  int n_cmp;
  int n_bad;

  tc4_calc_seq #(.DEBOUNCE_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .Sw    (Sw),
    .Enter (Enter),
    .Op    (Op),
    .N     (N),
    .Ovf   (Ovf),
    .Mode  (Mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press;
    Enter = 1'b1;
    wait_cyc(30);
    Enter = 1'b0;
    wait_cyc(30);
  endtask

  task automatic test_reset;
    reset = 1'b1; Sw = 4'b1010; Op = 1'b1; Enter = 1'b0;
    wait_cyc(3);
    n_cmp++; if (Mode !== 2'b00) begin n_bad++; $display("FAIL reset_mode got %b want 00", Mode); end
    n_cmp++; if (N !== 4'b0000) begin n_bad++; $display("FAIL reset_n got %b want 0000", N); end
    n_cmp++; if (Ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", Ovf); end
    reset = 1'b0;
    wait_cyc(1);
    n_cmp++; if (N !== 4'b1010) begin n_bad++; $display("FAIL post_reset_n got %b want 1010", N); end
    wait_cyc(5);
  endtask

  task automatic test_load_follow;
    Sw = 4'b0101;
    n_cmp++; if (N !== 4'b1010) begin n_bad++; $display("FAIL follow_before got %b want 1010", N); end
    wait_cyc(1);
    n_cmp++; if (N !== 4'b0101) begin n_bad++; $display("FAIL follow_after got %b want 0101", N); end
    n_cmp++; if (Ovf !== 1'b0) begin n_bad++; $display("FAIL follow_ovf got %b want 0", Ovf); end
  endtask

`ifndef TC4_CALC_DEBOUNCE_EN
  task automatic test_latency;
    Sw = 4'b0001;
    Enter = 1'b1;
    wait_cyc(3);
    n_cmp++; if (Mode !== 2'b00) begin n_bad++; $display("FAIL latency_early got %b want 00", Mode); end
    wait_cyc(1);
    n_cmp++; if (Mode !== 2'b01) begin n_bad++; $display("FAIL latency_edge3 got %b want 01", Mode); end
    Enter = 1'b0;
    wait_cyc(10);
    press;
    press;
    n_cmp++; if (Mode !== 2'b00) begin n_bad++; $display("FAIL latency_return got %b want 00", Mode); end
  endtask
`else
  task automatic test_glitch;
    Enter = 1'b1;
    wait_cyc(3);
    Enter = 1'b0;
    wait_cyc(40);
    n_cmp++; if (Mode !== 2'b00) begin n_bad++; $display("FAIL glitch_mode got %b want 00", Mode); end
  endtask
`endif

  task automatic test_calc(input string nm, input logic [3:0] a, input logic [3:0] b,
                           input logic op, input logic [3:0] exp_n, input logic exp_ovf);
    Sw = a; Op = 1'b0;
    press;
    n_cmp++; if (Mode !== 2'b01) begin n_bad++; $display("FAIL %s mode_b got %b want 01", nm, Mode); end
    Sw = b; Op = op;
    wait_cyc(1);
    n_cmp++; if (N !== b) begin n_bad++; $display("FAIL %s n_b got %b want %b", nm, N, b); end
    n_cmp++; if (Ovf !== 1'b0) begin n_bad++; $display("FAIL %s ovf_b got %b want 0", nm, Ovf); end
    press;
    n_cmp++; if (Mode !== 2'b10) begin n_bad++; $display("FAIL %s mode_r got %b want 10", nm, Mode); end
    n_cmp++; if (N !== exp_n) begin n_bad++; $display("FAIL %s result got %b want %b", nm, N, exp_n); end
    n_cmp++; if (Ovf !== exp_ovf) begin n_bad++; $display("FAIL %s ovf got %b want %b", nm, Ovf, exp_ovf); end
    Sw = ~b; Op = ~op;
    wait_cyc(5);
    n_cmp++; if (N !== exp_n) begin n_bad++; $display("FAIL %s hold_n got %b want %b", nm, N, exp_n); end
    n_cmp++; if (Ovf !== exp_ovf) begin n_bad++; $display("FAIL %s hold_ovf got %b want %b", nm, Ovf, exp_ovf); end
    press;
    n_cmp++; if (Mode !== 2'b00) begin n_bad++; $display("FAIL %s mode_a got %b want 00", nm, Mode); end
    n_cmp++; if (Ovf !== 1'b0) begin n_bad++; $display("FAIL %s ovf_clr got %b want 0", nm, Ovf); end
    n_cmp++; if (N !== ~b) begin n_bad++; $display("FAIL %s n_a got %b want %b", nm, N, ~b); end
  endtask

  task automatic test_held;
    Sw = 4'b0010;
    Enter = 1'b1;
    wait_cyc(50);
    n_cmp++; if (Mode !== 2'b01) begin n_bad++; $display("FAIL held_mode got %b want 01", Mode); end
    Enter = 1'b0;
    wait_cyc(30);
    n_cmp++; if (Mode !== 2'b01) begin n_bad++; $display("FAIL held_release got %b want 01", Mode); end
    press;
    press;
    n_cmp++; if (Mode !== 2'b00) begin n_bad++; $display("FAIL held_return got %b want 00", Mode); end
  endtask

  task automatic test_reset_press;
    Sw = 4'b0011;
    press;
    n_cmp++; if (Mode !== 2'b01) begin n_bad++; $display("FAIL rp_mode_b got %b want 01", Mode); end
    Sw = 4'b0110;
    Enter = 1'b1;
    wait_cyc(1);
    reset = 1'b1;
    wait_cyc(1);
    n_cmp++; if (Mode !== 2'b00) begin n_bad++; $display("FAIL rp_mode got %b want 00", Mode); end
    n_cmp++; if (N !== 4'b0000) begin n_bad++; $display("FAIL rp_n got %b want 0000", N); end
    n_cmp++; if (Ovf !== 1'b0) begin n_bad++; $display("FAIL rp_ovf got %b want 0", Ovf); end
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(40);
    n_cmp++; if (Mode !== 2'b00) begin n_bad++; $display("FAIL rp_no_advance got %b want 00", Mode); end
    n_cmp++; if (N !== 4'b0110) begin n_bad++; $display("FAIL rp_follow got %b want 0110", N); end
    Enter = 1'b0;
    wait_cyc(30);
    press;
    n_cmp++; if (Mode !== 2'b01) begin n_bad++; $display("FAIL rp_repress got %b want 01", Mode); end
    press;
    press;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1; Sw = 4'b0000; Enter = 1'b0; Op = 1'b0;
    test_reset;
    test_load_follow;
`ifndef TC4_CALC_DEBOUNCE_EN
    test_latency;
`else
    test_glitch;
`endif
    test_calc("add_3_4",    4'b0011, 4'b0100, 1'b0, 4'b0111, 1'b0);
    test_calc("add_5_4",    4'b0101, 4'b0100, 1'b0, 4'b1001, 1'b1);
    test_calc("sub_m8_1",   4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1);
    test_calc("sub_m1_1",   4'b1111, 4'b0001, 1'b1, 4'b1110, 1'b0);
    test_calc("sub_7_m1",   4'b0111, 4'b1111, 1'b1, 4'b1000, 1'b1);
    test_calc("add_m4_m4",  4'b1100, 4'b1100, 1'b0, 4'b1000, 1'b0);
    test_held;
    test_reset_press;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
